// File: rtl/pattern_response_checker.sv
// Capture end of the pattern-test chain: compacts WIDTH-bit response beats into a MISR
// signature over a programmed run length, watches for stalled producers, and reports pass/fail.
module pattern_response_checker #(
  parameter int unsigned           WIDTH     = 13,
  parameter int unsigned           SIG_WIDTH = 16,
  parameter logic [SIG_WIDTH-1:0]  POLY      = 16'h1021,
  parameter logic [SIG_WIDTH-1:0]  SEED      = 16'hFFFF,
  parameter int unsigned           TIMEOUT   = 255
) (
  input  logic                 blif_clk_net,
  input  logic                 blif_reset_net,
  input  logic                 start,
  input  logic [15:0]          num_vectors,
  input  logic [SIG_WIDTH-1:0] expected_sig,
  input  logic                 resp_valid,
  input  logic [WIDTH-1:0]     resp_data,
  output logic                 resp_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 timeout,
  output logic [SIG_WIDTH-1:0] signature,
  output logic [15:0]          beat_count
);

  localparam int unsigned IdleW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StRun, StCheck, StDone} state_e;

  state_e               state_q, state_d;
  logic [SIG_WIDTH-1:0] sig_q, sig_d;
  logic [SIG_WIDTH-1:0] exp_q, exp_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [15:0]          nv_q, nv_d;
  logic [IdleW-1:0]     idle_q, idle_d;
  logic                 timeout_q, timeout_d;
  logic                 pass_q, pass_d;

  logic                 accept;
  logic [IdleW-1:0]     idle_inc;
  logic [15:0]          cnt_inc;
  logic [SIG_WIDTH-1:0] data_ext;
  logic [SIG_WIDTH-1:0] misr_next;

  assign accept   = (state_q == StRun) && resp_valid;
  assign idle_inc = idle_q + IdleW'(1);
  assign cnt_inc  = cnt_q + 16'd1;
  assign data_ext = SIG_WIDTH'(resp_data);
  // Galois-style MISR: shift left, fold the outgoing MSB back through the taps, then mix data.
  assign misr_next = {sig_q[SIG_WIDTH-2:0], 1'b0} ^ (sig_q[SIG_WIDTH-1] ? POLY : '0) ^ data_ext;

  always_comb begin
    state_d   = state_q;
    sig_d     = sig_q;
    exp_d     = exp_q;
    cnt_d     = cnt_q;
    nv_d      = nv_q;
    idle_d    = idle_q;
    timeout_d = timeout_q;
    pass_d    = pass_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          sig_d     = SEED;
          cnt_d     = '0;
          idle_d    = '0;
          nv_d      = num_vectors;
          exp_d     = expected_sig;
          timeout_d = 1'b0;
          pass_d    = 1'b0;
          state_d   = (num_vectors == 16'd0) ? StCheck : StRun;
        end
      end
      StRun: begin
        // An accepted beat always wins over the idle threshold.
        if (accept) begin
          sig_d  = misr_next;
          cnt_d  = cnt_inc;
          idle_d = '0;
          if (cnt_inc == nv_q) state_d = StCheck;
        end else if (idle_inc == IdleW'(TIMEOUT)) begin
          idle_d    = idle_inc;
          timeout_d = 1'b1;
          state_d   = StCheck;
        end else begin
          idle_d = idle_inc;
        end
      end
      StCheck: begin
        pass_d  = !timeout_q && (sig_q == exp_q);
        state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
    if (!blif_reset_net) begin
      state_q   <= StIdle;
      sig_q     <= SEED;
      exp_q     <= '0;
      cnt_q     <= '0;
      nv_q      <= '0;
      idle_q    <= '0;
      timeout_q <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sig_q     <= sig_d;
      exp_q     <= exp_d;
      cnt_q     <= cnt_d;
      nv_q      <= nv_d;
      idle_q    <= idle_d;
      timeout_q <= timeout_d;
      pass_q    <= pass_d;
    end
  end

  assign resp_ready = (state_q == StRun);
  assign busy       = (state_q == StRun) || (state_q == StCheck);
  assign done       = (state_q == StDone);
  assign pass       = pass_q;
  assign timeout    = timeout_q;
  assign signature  = sig_q;
  assign beat_count = cnt_q;

endmodule

// File: tb/tb_pattern_response_checker.sv
// Self-checking bench for pattern_response_checker: random response streams compared against
// an arithmetic MISR model, plus reset, zero-length, timeout and restart scenarios.
module tb_pattern_response_checker;

  localparam logic [15:0] Poly = 16'h1021;
  localparam logic [15:0] Seed = 16'hFFFF;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] num_vectors;
  logic [15:0] expected_sig;
  logic        resp_valid;
  logic [12:0] resp_data;
  logic        resp_ready;
  logic        busy;
  logic        done;
  logic        pass;
  logic        timeout;
  logic [15:0] signature;
  logic [15:0] beat_count;

  int total;
  int bad;

  pattern_response_checker dut (
    .blif_clk_net  (clk),
    .blif_reset_net(rst_n),
    .start         (start),
    .num_vectors   (num_vectors),
    .expected_sig  (expected_sig),
    .resp_valid    (resp_valid),
    .resp_data     (resp_data),
    .resp_ready    (resp_ready),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .timeout       (timeout),
    .signature     (signature),
    .beat_count    (beat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: signature as a polynomial over GF(2), multiplied by x modulo POLY, plus data.
  function automatic logic [15:0] model_step(input logic [15:0] s, input logic [12:0] d);
    int unsigned v;
    v = int'(s) * 2;
    if (v >= 65536) v = (v - 65536) ^ int'(Poly);
    return 16'(v) ^ {3'b000, d};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [15:0] nv, input logic [15:0] es);
    start        = 1'b1;
    num_vectors  = nv;
    expected_sig = es;
    step();
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [12:0] d);
    resp_valid = 1'b1;
    resp_data  = d;
    step();
    resp_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] outs;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    outs = {resp_ready, busy, done, pass, timeout, 3'b000};
    total++;
    if (outs !== 8'h00) begin
      bad++;
      $display("FAIL reset_flags: got %b want 00000000", outs);
    end
    total++;
    if (signature !== Seed || beat_count !== 16'd0) begin
      bad++;
      $display("FAIL reset_sig: got sig=%h cnt=%0d want sig=%h cnt=0", signature, beat_count, Seed);
    end
    // Abort mid-run after three beats; reset must take effect without a clock edge.
    pulse_start(16'd10, 16'h0000);
    for (int i = 0; i < 3; i++) send_beat(13'($urandom_range(0, 8191)));
    total++;
    if (beat_count !== 16'd3) begin
      bad++;
      $display("FAIL midrun_count: got %0d want 3", beat_count);
    end
    rst_n = 1'b0;
    #1;
    outs = {resp_ready, busy, done, pass, timeout, 3'b000};
    total++;
    if (outs !== 8'h00 || signature !== 16'hFFFF || beat_count !== 16'd0) begin
      bad++;
      $display("FAIL async_reset: got flags=%b sig=%h cnt=%0d want 00000000 ffff 0",
               outs, signature, beat_count);
    end
    #1;
    rst_n = 1'b1;
    step();
    total++;
    if (busy !== 1'b0 || resp_ready !== 1'b0) begin
      bad++;
      $display("FAIL after_reset_idle: got busy=%b ready=%b want 0 0", busy, resp_ready);
    end
  endtask

  task automatic test_zero_length();
    pulse_start(16'd0, 16'hFFFF);
    total++;
    if (done !== 1'b0 || resp_ready !== 1'b0) begin
      bad++;
      $display("FAIL zero_len_check: got done=%b ready=%b want 0 0", done, resp_ready);
    end
    step();
    total++;
    if (done !== 1'b1 || pass !== 1'b1 || beat_count !== 16'd0 || signature !== Seed) begin
      bad++;
      $display("FAIL zero_len_done: got done=%b pass=%b cnt=%0d sig=%h want 1 1 0 ffff",
               done, pass, beat_count, signature);
    end
  endtask

  task automatic test_single_beat();
    logic [15:0] exp_list [2];
    logic        pass_list [2];
    exp_list[0] = 16'hEFDF; pass_list[0] = 1'b1;
    exp_list[1] = 16'h0000; pass_list[1] = 1'b0;
    for (int r = 0; r < 2; r++) begin
      pulse_start(16'd1, exp_list[r]);
      send_beat(13'h0000);
      step();
      total++;
      if (done !== 1'b1 || signature !== 16'hEFDF || pass !== pass_list[r]) begin
        bad++;
        $display("FAIL single_beat_%0d: got done=%b sig=%h pass=%b want 1 efdf %b",
                 r, done, signature, pass, pass_list[r]);
      end
    end
  endtask

  task automatic test_stream();
    logic [12:0] data [64];
    logic [15:0] model;
    int          ready_errs;
    model = Seed;
    for (int i = 0; i < 64; i++) begin
      data[i] = 13'($urandom_range(0, 8191));
      model   = model_step(model, data[i]);
    end
    total++;
    if (resp_ready !== 1'b0) begin
      bad++;
      $display("FAIL ready_in_done: got %b want 0", resp_ready);
    end
    pulse_start(16'd64, model);
    ready_errs = 0;
    for (int i = 0; i < 64; i++) begin
      int gap;
      gap = $urandom_range(0, 10);
      for (int g = 0; g < gap; g++) begin
        resp_data = 13'($urandom_range(0, 8191));
        step();
      end
      if (resp_ready !== 1'b1) ready_errs++;
      send_beat(data[i]);
    end
    total++;
    if (ready_errs != 0) begin
      bad++;
      $display("FAIL stream_ready: got %0d beats with ready low want 0", ready_errs);
    end
    total++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL stream_check_cycle: got done=%b busy=%b want 0 1", done, busy);
    end
    step();
    total++;
    if (done !== 1'b1 || pass !== 1'b1 || beat_count !== 16'd64 || signature !== model) begin
      bad++;
      $display("FAIL stream_result: got done=%b pass=%b cnt=%0d sig=%h want 1 1 64 %h",
               done, pass, beat_count, signature, model);
    end
    total++;
    if (resp_ready !== 1'b0 || timeout !== 1'b0) begin
      bad++;
      $display("FAIL stream_done_ready: got ready=%b timeout=%b want 0 0", resp_ready, timeout);
    end
  endtask

  task automatic test_timeout();
    logic [15:0] model;
    logic [12:0] d;
    model = Seed;
    pulse_start(16'd8, 16'h1234);
    for (int i = 0; i < 5; i++) begin
      d     = 13'($urandom_range(0, 8191));
      model = model_step(model, d);
      send_beat(d);
    end
    for (int i = 0; i < 255; i++) step();
    total++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL timeout_early: got done=%b busy=%b want 0 1", done, busy);
    end
    step();
    total++;
    if (done !== 1'b1 || timeout !== 1'b1 || pass !== 1'b0) begin
      bad++;
      $display("FAIL timeout_flags: got done=%b timeout=%b pass=%b want 1 1 0", done, timeout, pass);
    end
    total++;
    if (beat_count !== 16'd5 || signature !== model) begin
      bad++;
      $display("FAIL timeout_frozen: got cnt=%0d sig=%h want 5 %h", beat_count, signature, model);
    end
  endtask

  task automatic test_restart();
    logic [12:0] d [6];
    logic [15:0] model;
    model = Seed;
    for (int i = 0; i < 6; i++) begin
      d[i]  = 13'($urandom_range(0, 8191));
      model = model_step(model, d[i]);
    end
    pulse_start(16'd6, model);
    send_beat(d[0]);
    send_beat(d[1]);
    // Start during RUN with different run parameters must be ignored.
    start        = 1'b1;
    num_vectors  = 16'd3;
    expected_sig = 16'h0000;
    send_beat(d[2]);
    start = 1'b0;
    total++;
    if (beat_count !== 16'd3 || busy !== 1'b1) begin
      bad++;
      $display("FAIL start_ignored: got cnt=%0d busy=%b want 3 1", beat_count, busy);
    end
    for (int i = 3; i < 6; i++) send_beat(d[i]);
    step();
    total++;
    if (done !== 1'b1 || pass !== 1'b1 || signature !== model) begin
      bad++;
      $display("FAIL restart_run1: got done=%b pass=%b sig=%h want 1 1 %h",
               done, pass, signature, model);
    end
    model = Seed;
    for (int i = 0; i < 4; i++) begin
      d[i]  = 13'($urandom_range(0, 8191));
      model = model_step(model, d[i]);
    end
    pulse_start(16'd4, model);
    total++;
    if (done !== 1'b0 || pass !== 1'b0 || signature !== Seed || beat_count !== 16'd0 ||
        resp_ready !== 1'b1) begin
      bad++;
      $display("FAIL restart_from_done: got done=%b pass=%b sig=%h cnt=%0d ready=%b want 0 0 ffff 0 1",
               done, pass, signature, beat_count, resp_ready);
    end
    for (int i = 0; i < 4; i++) send_beat(d[i]);
    step();
    total++;
    if (done !== 1'b1 || pass !== 1'b1 || beat_count !== 16'd4 || signature !== model) begin
      bad++;
      $display("FAIL restart_run2: got done=%b pass=%b cnt=%0d sig=%h want 1 1 4 %h",
               done, pass, beat_count, signature, model);
    end
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    rst_n        = 1'b0;
    start        = 1'b0;
    num_vectors  = 16'd0;
    expected_sig = 16'd0;
    resp_valid   = 1'b0;
    resp_data    = 13'd0;
    test_reset();
    test_zero_length();
    test_single_beat();
    test_stream();
    test_timeout();
    test_restart();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
